// File: rtl/timer_multi.sv
// NCH independent prescaled up-counters with period match, compare-driven PWM and a shared IRQ.
// Register writes land on the next edge. dout is combinational. pwm_out lags COUNT by one cycle.
module timer_multi #(
   parameter int               WIDTH       = 32,
   parameter int               NCH         = 4,
   parameter logic [WIDTH-1:0] PERIOD_INIT = 'hF,
   parameter logic             EN_INIT     = 1'b0,
   parameter int               AW          = $clog2(NCH) + 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   input  logic             wren,
   input  logic             rden,
   input  logic [AW-1:0]    addr,
   output logic             irq,
   output logic [NCH-1:0]   toggle_out,
   output logic [NCH-1:0]   pwm_out
);

   localparam logic [1:0] REG_COUNT   = 2'd0;
   localparam logic [1:0] REG_PERIOD  = 2'd1;
   localparam logic [1:0] REG_CTRL    = 2'd2;
   localparam logic [1:0] REG_COMPARE = 2'd3;

   logic [WIDTH-1:0] r_count   [NCH];
   logic [WIDTH-1:0] r_period  [NCH];
   logic [WIDTH-1:0] r_compare [NCH];
   logic [7:0]       r_ps_cnt  [NCH];
   logic [7:0]       r_ps      [NCH];
   logic [NCH-1:0]   r_en, r_flag, r_toggle, r_oneshot, r_ie, r_pwm;

   logic [AW-1:0]  w_ch;
   logic [1:0]     w_reg;
   logic [NCH-1:0] w_sel, w_tick, w_match;
   logic [NCH-1:0] w_wr_cnt, w_wr_per, w_wr_ctl, w_wr_cmp, w_rd_ctl;

   assign w_ch  = addr >> 2;
   assign w_reg = addr[1:0];

   // Out-of-range channel indices select nothing, so they read 0 and drop writes.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_sel[i]    = (w_ch == AW'(i));
         w_wr_cnt[i] = wren & w_sel[i] & (w_reg == REG_COUNT);
         w_wr_per[i] = wren & w_sel[i] & (w_reg == REG_PERIOD);
         w_wr_ctl[i] = wren & w_sel[i] & (w_reg == REG_CTRL);
         w_wr_cmp[i] = wren & w_sel[i] & (w_reg == REG_COMPARE);
         w_rd_ctl[i] = rden & w_sel[i] & (w_reg == REG_CTRL);
         w_tick[i]   = r_en[i] & (r_ps_cnt[i] == r_ps[i]);
         // A software COUNT write overrides the match and all of its side effects.
         w_match[i]  = w_tick[i] & (r_count[i] == r_period[i]) & ~w_wr_cnt[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NCH; i++) begin
            r_count[i]   <= '0;
            r_period[i]  <= PERIOD_INIT;
            r_compare[i] <= '0;
            r_ps_cnt[i]  <= '0;
            r_ps[i]      <= '0;
            r_en[i]      <= EN_INIT;
            r_flag[i]    <= 1'b0;
            r_toggle[i]  <= 1'b0;
            r_oneshot[i] <= 1'b0;
            r_ie[i]      <= 1'b0;
            r_pwm[i]     <= 1'b0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (!r_en[i] || w_tick[i]) r_ps_cnt[i] <= '0;
            else                       r_ps_cnt[i] <= r_ps_cnt[i] + 8'd1;

            if (w_wr_cnt[i])     r_count[i] <= din;
            else if (w_match[i]) r_count[i] <= '0;
            else if (w_tick[i])  r_count[i] <= r_count[i] + WIDTH'(1);

            if (w_wr_per[i]) r_period[i]  <= din;
            if (w_wr_cmp[i]) r_compare[i] <= din;

            // Hardware match beats both a CTRL write and the read-to-clear.
            if (w_match[i])       r_flag[i] <= 1'b1;
            else if (w_wr_ctl[i]) r_flag[i] <= din[1];
            else if (w_rd_ctl[i]) r_flag[i] <= 1'b0;

            if (w_match[i])       r_toggle[i] <= ~r_toggle[i];
            else if (w_wr_ctl[i]) r_toggle[i] <= din[2];

            if (w_wr_ctl[i]) begin
               r_en[i]      <= din[0] & ~(w_match[i] & din[3]);
               r_oneshot[i] <= din[3];
               r_ie[i]      <= din[4];
               r_ps[i]      <= din[15:8];
            end else if (w_match[i] && r_oneshot[i]) begin
               r_en[i] <= 1'b0;
            end

            r_pwm[i] <= r_en[i] & (r_count[i] < r_compare[i]);
         end
      end
   end

   always_comb begin
      dout = '0;
      for (int i = 0; i < NCH; i++) begin
         if (rden && w_sel[i]) begin
            case (w_reg)
               REG_COUNT:  dout = r_count[i];
               REG_PERIOD: dout = r_period[i];
               REG_CTRL: begin
                  dout[0]    = r_en[i];
                  dout[1]    = r_flag[i];
                  dout[2]    = r_toggle[i];
                  dout[3]    = r_oneshot[i];
                  dout[4]    = r_ie[i];
                  dout[15:8] = r_ps[i];
               end
               default:    dout = r_compare[i];
            endcase
         end
      end
   end

   assign irq        = |(r_flag & r_ie);
   assign toggle_out = r_toggle;
   assign pwm_out    = r_pwm;

endmodule

// File: tb/tb_timer_multi.sv
// Directed bench for timer_multi: five channels so that channel index 5 is a real out-of-range address.
module tb_timer_multi;

   localparam int NCH = 5;
   localparam int AW  = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   din;
   logic [31:0]   dout;
   logic          wren, rden;
   logic [AW-1:0] addr;
   logic          irq;
   logic [NCH-1:0] toggle_out, pwm_out;

   int n_checks = 0;
   int n_fail   = 0;

   timer_multi #(.WIDTH(32), .NCH(NCH)) dut (
      .clk(clk), .reset(reset), .din(din), .dout(dout), .wren(wren), .rden(rden),
      .addr(addr), .irq(irq), .toggle_out(toggle_out), .pwm_out(pwm_out)
   );

   always #5 clk = ~clk;

   function automatic int A(input int ch, input int r);
      return ch * 4 + r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      addr = AW'(a);
      din  = d;
      wren = 1'b1;
      @(negedge clk);
      wren = 1'b0;
   endtask

   task automatic rchk(input string tag, input int a, input logic [31:0] exp);
      logic [31:0] v;
      addr = AW'(a);
      rden = 1'b1;
      #1 v = dout;
      chk(tag, v, exp);
      @(negedge clk);
      rden = 1'b0;
   endtask

   task automatic check_reset_state();
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_pwm", {27'd0, pwm_out}, 32'd0);
      chk("rst_toggle", {27'd0, toggle_out}, 32'd0);
      for (int c = 0; c < NCH; c++)
         for (int r = 0; r < 4; r++)
            rchk($sformatf("rst_ch%0d_r%0d", c, r), A(c, r), (r == 1) ? 32'hF : 32'h0);
   endtask

   initial begin
      reset = 1'b1; wren = 1'b0; rden = 1'b0; addr = '0; din = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_reset_state();

      // Continuous mode, ch1, PERIOD=3
      wr(A(1, 1), 32'd3);
      wr(A(1, 2), 32'h11);
      for (int k = 0; k <= 8; k++) begin
         chk($sformatf("cont_irq_%0d", k), {31'd0, irq}, (k >= 4) ? 32'd1 : 32'd0);
         chk($sformatf("cont_tog_%0d", k), {31'd0, toggle_out[1]}, 32'((k / 4) % 2));
         rchk($sformatf("cont_cnt_%0d", k), A(1, 0), 32'(k % 4));
      end
      rchk("cont_ctrl_flag", A(1, 2), 32'h13);
      chk("cont_irq_pre_clear", {31'd0, irq}, 32'd0);
      rchk("cont_ctrl_clr", A(1, 2), 32'h11);
      // Disable lands on a match cycle: FLAG and TOGGLE still taken by hardware.
      wr(A(1, 2), 32'h0);
      rchk("ctrlwr_match", A(1, 2), 32'h06);
      rchk("ch1_hold", A(1, 0), 32'd0);

      // Prescaler, ch2, PERIOD=1, PS=2
      wr(A(2, 1), 32'd1);
      wr(A(2, 2), 32'h0201);
      for (int k = 0; k <= 14; k++) begin
         chk($sformatf("ps_tog_%0d", k), {31'd0, toggle_out[2]}, 32'((k / 6) % 2));
         rchk($sformatf("ps_cnt_%0d", k), A(2, 0), 32'((k / 3) % 2));
      end
      wr(A(2, 2), 32'h0);

      // One-shot, ch3, PERIOD=5
      wr(A(3, 1), 32'd5);
      wr(A(3, 2), 32'h09);
      for (int k = 0; k <= 26; k++)
         rchk($sformatf("os_cnt_%0d", k), A(3, 0), (k <= 5) ? 32'(k) : 32'd0);
      rchk("os_ctrl", A(3, 2), 32'h0E);

      // PWM, ch0, PERIOD=9, COMPARE=3
      wr(A(0, 1), 32'd9);
      wr(A(0, 3), 32'd3);
      wr(A(0, 2), 32'h01);
      for (int k = 0; k <= 20; k++) begin
         chk($sformatf("pwm_%0d", k), {31'd0, pwm_out[0]},
             ((k >= 1) && (((k - 1) % 10) < 3)) ? 32'd1 : 32'd0);
         rchk($sformatf("pwm_cnt_%0d", k), A(0, 0), 32'(k % 10));
      end
      wr(A(0, 3), 32'd0);
      @(negedge clk);
      for (int k = 0; k < 12; k++) begin
         chk($sformatf("pwm_cmp0_%0d", k), {31'd0, pwm_out[0]}, 32'd0);
         @(negedge clk);
      end
      wr(A(0, 2), 32'h0);

      // Collisions on ch4, PERIOD=2
      wr(A(4, 1), 32'd2);
      wr(A(4, 2), 32'h11);
      repeat (2) @(negedge clk);
      rchk("rd_in_match", A(4, 2), 32'h11);
      chk("rd_in_match_irq", {31'd0, irq}, 32'd1);
      rchk("rd_in_match_flag", A(4, 2), 32'h17);
      rchk("rd_clear", A(4, 2), 32'h15);
      wr(A(4, 0), 32'd7);
      rchk("cntwr_match_cnt", A(4, 0), 32'd7);
      chk("cntwr_match_irq", {31'd0, irq}, 32'd0);
      rchk("cntwr_match_ctrl", A(4, 2), 32'h15);
      wr(A(4, 2), 32'h0);

      // Wrap-around from 0xFFFFFFFF on ch3
      wr(A(3, 1), 32'hF);
      wr(A(3, 0), 32'hFFFF_FFFF);
      wr(A(3, 2), 32'h01);
      rchk("wrap_max", A(3, 0), 32'hFFFF_FFFF);
      rchk("wrap_zero", A(3, 0), 32'd0);
      rchk("wrap_noflag", A(3, 2), 32'h01);
      repeat (13) @(negedge clk);
      rchk("wrap_cnt_f", A(3, 0), 32'hF);
      rchk("wrap_match", A(3, 2), 32'h07);
      wr(A(3, 2), 32'h0);

      // Out-of-range channel index 5
      wr(A(5, 1), 32'h55);
      wr(A(5, 0), 32'h66);
      for (int r = 0; r < 4; r++)
         rchk($sformatf("oor_r%0d", r), A(5, r), 32'd0);
      rchk("oor_ch0_per", A(0, 1), 32'd9);
      rchk("oor_ch1_per", A(1, 1), 32'd3);
      rchk("oor_ch1_cnt", A(1, 0), 32'd0);
      addr = AW'(A(0, 1));
      #1 chk("dout_idle", dout, 32'd0);
      @(negedge clk);

      // Reset while ch1 is counting
      wr(A(1, 2), 32'h11);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1 chk("rst_async_toggle", {27'd0, toggle_out}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      check_reset_state();
      repeat (3) @(negedge clk);
      rchk("rst_no_count", A(1, 0), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
